// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state, op encodings and timing defaults for the game frame controller
package game_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START_WAIT,
        ST_CLEAR,
        ST_LOAD,
        ST_DRAW,
        ST_CHECK,
        ST_WAIT,
        ST_ERASE,
        ST_OVER
    } game_state_t;

    localparam logic [1:0] OP_DRAW  = 2'b00;
    localparam logic [1:0] OP_ERASE = 2'b01;
    localparam logic [1:0] OP_OVER  = 2'b10;

    localparam int FRAME_TICKS_30HZ    = 1666666;
    localparam int PIX_PER_OBJ_DEFAULT = 250;

    // A single sprite still needs a one-bit select so the port never collapses to zero width.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_frame_ctrl_if.sv
// rtl/game_frame_ctrl_if.sv - control/strobe bundle between the frame controller and its neighbours
interface game_frame_ctrl_if #(
    parameter int OBJ_W   = 1,
    parameter int PIX_W   = 8,
    parameter int FRAME_W = 16
);
    logic               start;
    logic               pause;
    logic               collide;
    logic               plot;
    logic [1:0]         op;
    logic [OBJ_W-1:0]   obj_sel;
    logic [PIX_W-1:0]   pix_idx;
    logic               move_en;
    logic               load_coord;
    logic               dp_reset;
    logic               game_over;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        input  start, pause, collide,
        output plot, op, obj_sel, pix_idx, move_en, load_coord, dp_reset, game_over, frame_cnt
    );

    modport slave (
        output start, pause, collide,
        input  plot, op, obj_sel, pix_idx, move_en, load_coord, dp_reset, game_over, frame_cnt
    );
endinterface

// File: rtl/game_frame_ctrl_sprite_scan_cnt.sv
// rtl/game_frame_ctrl_sprite_scan_cnt.sv - nested sprite/pixel scan counter shared by draw, erase and recolour
module sprite_scan_cnt #(
    parameter int N_OBJ       = 2,
    parameter int PIX_PER_OBJ = 250,
    parameter int OBJ_W       = 1,
    parameter int PIX_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [OBJ_W-1:0] obj,
    output logic [PIX_W-1:0] pix,
    output logic             last
);
    localparam logic [OBJ_W-1:0] OBJ_LAST = OBJ_W'(N_OBJ - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_PER_OBJ - 1);

    assign last = (obj == OBJ_LAST) && (pix == PIX_LAST);

    // A full pass wraps back to (0,0), so the counter is already cleared when the pass ends.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            obj <= '0;
            pix <= '0;
        end else if (en) begin
            if (pix == PIX_LAST) begin
                pix <= '0;
                obj <= (obj == OBJ_LAST) ? '0 : obj + OBJ_W'(1);
            end else begin
                pix <= pix + PIX_W'(1);
            end
        end
    end
endmodule

// File: rtl/game_frame_ctrl.sv
// rtl/game_frame_ctrl.sv - frame loop sequencer: draw, collision check, timed wait, erase, game-over recolour
module game_frame_ctrl
    import game_pkg::*;
#(
    parameter int N_OBJ       = 2,
    parameter int PIX_PER_OBJ = PIX_PER_OBJ_DEFAULT,
    parameter int FRAME_TICKS = FRAME_TICKS_30HZ,
    parameter int FRAME_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    game_frame_ctrl_if.master ctrl
);
    localparam int OBJ_W  = sel_width(N_OBJ);
    localparam int PIX_W  = $clog2(PIX_PER_OBJ);
    localparam int WAIT_W = $clog2(FRAME_TICKS);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FRAME_TICKS - 1);

    game_state_t        state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic               over_done;

    logic               scan_clr;
    logic               scan_en;
    logic               scan_last;
    logic [OBJ_W-1:0]   scan_obj;
    logic [PIX_W-1:0]   scan_pix;

    assign scan_en  = (state == ST_DRAW) || (state == ST_ERASE) ||
                      ((state == ST_OVER) && !over_done);
    // Only leaving OVER can abandon a pass midway; every other exit happens on the wrap.
    assign scan_clr = (state == ST_OVER) && ctrl.start;

    sprite_scan_cnt #(
        .N_OBJ      (N_OBJ),
        .PIX_PER_OBJ(PIX_PER_OBJ),
        .OBJ_W      (OBJ_W),
        .PIX_W      (PIX_W)
    ) u_scan (
        .clk  (clk),
        .reset(reset),
        .clr  (scan_clr),
        .en   (scan_en),
        .obj  (scan_obj),
        .pix  (scan_pix),
        .last (scan_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            frame_cnt <= '0;
            over_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl.start) state <= ST_START_WAIT;
                end
                ST_START_WAIT: begin
                    if (!ctrl.start) state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    frame_cnt <= '0;
                    state     <= ST_LOAD;
                end
                ST_LOAD: begin
                    state <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (scan_last) state <= ST_CHECK;
                end
                ST_CHECK: begin
                    over_done <= 1'b0;
                    state     <= ctrl.collide ? ST_OVER : ST_WAIT;
                end
                ST_WAIT: begin
                    if (!ctrl.pause) begin
                        if (wait_cnt == WAIT_LAST) begin
                            wait_cnt <= '0;
                            if (frame_cnt != '1) frame_cnt <= frame_cnt + FRAME_W'(1);
                            state <= ST_ERASE;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                end
                ST_ERASE: begin
                    if (scan_last) state <= ST_LOAD;
                end
                ST_OVER: begin
                    if (ctrl.start) begin
                        over_done <= 1'b0;
                        state     <= ST_START_WAIT;
                    end else if (scan_last && !over_done) begin
                        over_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ctrl.plot       = scan_en;
    assign ctrl.op         = (state == ST_ERASE) ? OP_ERASE :
                             ((state == ST_OVER) && !over_done) ? OP_OVER : OP_DRAW;
    assign ctrl.obj_sel    = scan_obj;
    assign ctrl.pix_idx    = scan_pix;
    assign ctrl.move_en    = (state == ST_DRAW) || (state == ST_WAIT);
    assign ctrl.load_coord = (state == ST_LOAD);
    assign ctrl.dp_reset   = (state == ST_CLEAR);
    assign ctrl.game_over  = (state == ST_OVER);
    assign ctrl.frame_cnt  = frame_cnt;
endmodule
